adc_snapshot_uart: RTL
======================

// Module: adc_snapshot_uart
// PURPOSE
//  Downstream consumer of the registered 8-bit ADC sample stream (ADC clock domain).
//  Waits for a rising-edge level trigger or a forced trigger, then records DEPTH decimated
//  samples into an on-chip buffer. Sends the snapshot out over the FTDI serial line as
//  8N1 UART: a 0xA5 header followed by the samples.
//  Sits beside the LED display in the top level; TXD drives FTB1.
// PARAMETERS
//  DEPTH     256  samples per snapshot (power of two)
//  ADDR_W    8    log2(DEPTH)
//  BAUD_DIV  217  CLK cycles per UART bit (25 MHz / 115200)
// PORTS
//  CLK         in   1  ADC sample clock (PLL output); sole clock
//  RESET       in   1  synchronous, active-high reset
//  ADC_DATA    in   8  registered ADC sample, new value every CLK
//  ARM         in   1  one-cycle pulse: arm trigger (honoured only in IDLE)
//  FORCE_TRIG  in   1  trigger immediately when ARMED
//  TRIG_LEVEL  in   8  unsigned rising-edge threshold
//  DECIM       in   8  store every (DECIM+1)th sample; latched at trigger
//  TXD         out  1  UART transmit, idle high
//  BUSY        out  1  high in ARMED, CAPTURE, SEND
//  STATE       out  2  0=IDLE 1=ARMED 2=CAPTURE 3=SEND
// BEHAVIOUR
//  Reset values: TXD=1, BUSY=0, STATE=0. RESET mid-operation aborts at once:
//   - next cycle TXD=1 and STATE=IDLE
//   - no partial byte/stop bit completed; buffer contents don't-care
//  Internal: s_cur<=ADC_DATA each CLK; s_prev<=s_cur; prev_ok cleared on entry to ARMED,
//   set one cycle later.
//  IDLE: ARM -> ARMED. ARM in any other state is ignored.
//  ARMED: trigger on (prev_ok && s_prev<TRIG_LEVEL && s_cur>=TRIG_LEVEL) || FORCE_TRIG.
//   - On trigger: s_cur written to addr 0 that cycle; DECIM latched; dcnt=0;
//     STATE=CAPTURE next cycle.
//   - TRIG_LEVEL=0 never fires the level trigger (s_prev<0 impossible); FORCE only.
//  CAPTURE: dcnt counts to latched DECIM then wraps to 0. Each wrap stores s_cur at
//   wptr+1, so samples are spaced exactly DECIM+1 cycles (DECIM=0: consecutive).
//   - After the store to addr DEPTH-1 -> SEND next cycle.
//   - Trigger inputs ignored.
//  SEND: bytes sent in order 0xA5, buf[0] .. buf[DEPTH-1], total DEPTH+1 bytes.
//   - Frame: start(0), d0..d7 LSB first, stop(1); each bit exactly BAUD_DIV cycles.
//   - Next frame's start bit begins the cycle after the prior stop bit ends
//     (no idle gap); buffer read latency of 1 cycle hidden inside the stop bit.
//   - After the final stop bit -> IDLE; a new ARM is required for the next snapshot.
//  Widths: dcnt 8b; wptr/rptr ADDR_W+1b (MSB = done); baud cnt ceil(log2(BAUD_DIV))b;
//   bit cnt 4b.
// STRUCTURE
//  Package adc_snap_pkg:
//   - state enum (IDLE/ARMED/CAPTURE/SEND)
//   - HDR_BYTE=8'hA5
//   - default BAUD_DIV
//  Sub-module uart_tx_8n1 (BAUD_DIV): inputs data[7:0] and valid; outputs ready and txd.
//   - Accepts a byte when valid&&ready.
//   - ready rises on the last stop-bit cycle.
//  Buffer: inferred simple dual-port RAM, DEPTH x 8, synchronous read.
// TESTING
//  1 Reset: RESET high 3 cycles mid-SEND -> TXD=1, STATE=0 next cycle; line stays high.
//  2 Level trigger: TRIG_LEVEL=0x80, ramp 0x70..0x90 step 1, DECIM=0, ARM ->
//    buf[0]=0x80, buf[k]=0x80+k; serial stream 0xA5,0x80,0x81,...
//  3 Decimation: counter ramp ADC_DATA=cycle[7:0], FORCE_TRIG, DECIM=3 ->
//    successive bytes differ by 4; DEPTH+1 frames total.
//  4 No false trigger: constant 0xFF with TRIG_LEVEL=0x80 for 1000 cycles ->
//    stays ARMED, TXD high.
//  5 UART timing: BAUD_DIV=4 -> each bit 4 cycles, frame 40 cycles; header bits
//    1,0,1,0,0,1,0,1 LSB first; no gap between frames.
//  6 ARM during CAPTURE/SEND ignored; ARM after return to IDLE starts a fresh capture.

Source files
------------

// File: rtl/adc_snap_pkg.sv
// Shared definitions for the ADC snapshot UART block.
//   state_e          : controller state, numeric value is exported on STATE
//   HDR_BYTE         : first byte of every serial snapshot
//   DEFAULT_BAUD_DIV : clock cycles per UART bit at 25 MHz / 115200 baud
package adc_snap_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StSend    = 2'd3
  } state_e;

  localparam logic [7:0]  HDR_BYTE         = 8'hA5;
  localparam int unsigned DEFAULT_BAUD_DIV = 217;

endpackage

// File: rtl/adc_snapshot_uart_if.sv
// Signal bundle between the ADC snapshot block and its surroundings.
//   ADC_DATA   : registered ADC sample, new value every clock
//   ARM        : one-cycle pulse, arms the trigger from idle
//   FORCE_TRIG : immediate trigger while armed
//   TRIG_LEVEL : unsigned rising-edge threshold
//   DECIM      : store every (DECIM+1)th sample
//   TXD        : 8N1 serial output, idle high
//   BUSY       : high whenever not idle
//   STATE      : 0 idle, 1 armed, 2 capture, 3 send
// master drives the control inputs; slave is the snapshot block.
interface adc_snapshot_uart_if;
  logic [7:0] ADC_DATA;
  logic       ARM;
  logic       FORCE_TRIG;
  logic [7:0] TRIG_LEVEL;
  logic [7:0] DECIM;
  logic       TXD;
  logic       BUSY;
  logic [1:0] STATE;

  modport master (
    output ADC_DATA, ARM, FORCE_TRIG, TRIG_LEVEL, DECIM,
    input  TXD, BUSY, STATE
  );

  modport slave (
    input  ADC_DATA, ARM, FORCE_TRIG, TRIG_LEVEL, DECIM,
    output TXD, BUSY, STATE
  );
endinterface

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter with a valid/ready byte input.
//   clk   : clock
//   rst   : synchronous active-high reset, drops any frame in flight
//   data  : byte to send, taken when valid && ready
//   valid : byte available
//   ready : idle, or in the last cycle of the stop bit (back-to-back frames)
//   txd   : serial line, idle high; start(0), d0..d7 LSB first, stop(1)
module uart_tx_8n1 #(
  parameter int unsigned BAUD_DIV = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       txd
);

  localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(BAUD_DIV - 1);

  logic            active_q;
  logic [CntW-1:0] baud_cnt_q;
  logic [3:0]      bit_cnt_q;
  // Bit 0 is the bit currently on the line; ones shift in from the top.
  logic [9:0]      shift_q;

  logic baud_last;
  logic accept;

  assign baud_last = (baud_cnt_q == BaudLast);
  assign ready     = !active_q || ((bit_cnt_q == 4'd9) && baud_last);
  assign accept    = valid && ready;
  assign txd       = active_q ? shift_q[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q   <= 1'b0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '1;
    end else if (accept) begin
      active_q   <= 1'b1;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= {1'b1, data, 1'b0};
    end else if (active_q) begin
      if (baud_last) begin
        baud_cnt_q <= '0;
        shift_q    <= {1'b1, shift_q[9:1]};
        if (bit_cnt_q == 4'd9) begin
          active_q <= 1'b0;
        end else begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end else begin
        baud_cnt_q <= baud_cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/adc_snapshot_uart.sv
// ADC snapshot recorder with UART readout.
// Waits for a rising-edge level crossing or a forced trigger, records DEPTH decimated
// samples into a local RAM, then sends 0xA5 followed by the samples as 8N1 UART.
//   CLK   : ADC sample clock, sole clock
//   RESET : synchronous active-high reset, aborts any capture or transmission
//   bus   : slave side of adc_snapshot_uart_if (sample, controls, TXD/BUSY/STATE)
module adc_snapshot_uart
  import adc_snap_pkg::*;
#(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic                CLK,
  input  logic                RESET,
  adc_snapshot_uart_if.slave  bus
);

  localparam logic [ADDR_W:0] LastAddr = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PtrOne   = (ADDR_W + 1)'(1);

  state_e          state_q, state_d;
  logic [7:0]      s_cur_q, s_prev_q;
  logic            prev_ok_q;
  logic [7:0]      decim_q, decim_d;
  logic [7:0]      dcnt_q, dcnt_d;
  // Pointer MSB flags completion; low bits address the buffer.
  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic [ADDR_W:0] wptr_inc;
  logic            hdr_q, hdr_d;

  logic            we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]      wdata;
  logic [7:0]      mem [DEPTH];
  logic [7:0]      rd_data_q;

  logic            level_trig;
  logic            trig;
  logic            tx_valid;
  logic            tx_ready;
  logic [7:0]      tx_data;
  logic            txd;

  // s_prev < 0 is impossible, so TRIG_LEVEL=0 can only fire via FORCE_TRIG.
  assign level_trig = prev_ok_q && (s_prev_q < bus.TRIG_LEVEL) &&
                      (s_cur_q >= bus.TRIG_LEVEL);
  assign trig       = level_trig || bus.FORCE_TRIG;
  assign wptr_inc   = wptr_q + PtrOne;

  always_comb begin
    state_d  = state_q;
    decim_d  = decim_q;
    dcnt_d   = dcnt_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    hdr_d    = hdr_q;
    we       = 1'b0;
    waddr    = wptr_q[ADDR_W-1:0];
    wdata    = s_cur_q;
    tx_valid = 1'b0;
    tx_data  = hdr_q ? HDR_BYTE : rd_data_q;
    unique case (state_q)
      StIdle: begin
        if (bus.ARM) state_d = StArmed;
      end
      StArmed: begin
        if (trig) begin
          we      = 1'b1;
          waddr   = '0;
          wptr_d  = '0;
          dcnt_d  = 8'd0;
          decim_d = bus.DECIM;
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (dcnt_q == decim_q) begin
          dcnt_d = 8'd0;
          we     = 1'b1;
          waddr  = wptr_inc[ADDR_W-1:0];
          wptr_d = wptr_inc;
          if (wptr_inc == LastAddr) begin
            state_d = StSend;
            rptr_d  = '0;
            hdr_d   = 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end
      StSend: begin
        // Buffer is read continuously at rptr, so the next byte is settled
        // well before the transmitter asks for it in the stop bit.
        tx_valid = hdr_q || !rptr_q[ADDR_W];
        if (tx_ready) begin
          if (hdr_q) begin
            hdr_d = 1'b0;
          end else if (!rptr_q[ADDR_W]) begin
            rptr_d = rptr_q + PtrOne;
          end else begin
            // All bytes handed over and the last stop bit is ending.
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      s_cur_q   <= 8'd0;
      s_prev_q  <= 8'd0;
      prev_ok_q <= 1'b0;
      decim_q   <= 8'd0;
      dcnt_q    <= 8'd0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      hdr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_cur_q   <= bus.ADC_DATA;
      s_prev_q  <= s_cur_q;
      // Low in the first armed cycle, so a stale s_prev cannot trigger.
      prev_ok_q <= (state_q == StArmed);
      decim_q   <= decim_d;
      dcnt_q    <= dcnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      hdr_q     <= hdr_d;
    end
  end

  // Simple dual-port buffer, synchronous read.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    rd_data_q <= mem[rptr_q[ADDR_W-1:0]];
  end

  uart_tx_8n1 #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk  (CLK),
    .rst  (RESET),
    .data (tx_data),
    .valid(tx_valid),
    .ready(tx_ready),
    .txd  (txd)
  );

  assign bus.TXD   = txd;
  assign bus.BUSY  = (state_q != StIdle);
  assign bus.STATE = state_q;

endmodule
